memory_access: RTL

Memory-access (MEM) stage of the 5-stage MIPS pipeline. It sits directly downstream of the execute stage: it takes the registered EX/MEM result, store data and control, performs little-endian byte/halfword/word loads and stores on a local data memory, and registers the MEM/WB pipeline state. Its `o_wb_data` output is the write-back value that is forwarded to the execute stage as the MEM/WB operand. A combinational debug read port lets the debug unit dump memory while the core is halted.

---
 rtl/memory_access.sv | 98 +++++++++
 1 files changed

// File: rtl/memory_access.sv
// MEM stage: byte/halfword/word loads and stores on a local data memory,
// plus the MEM/WB pipeline register and a combinational debug read port.
module memory_access #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [4:0]         i_write_reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic               i_mem2reg,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [4:0]         o_write_reg,
    output logic               o_regWrite,
    output logic               o_mem2reg,
    output logic [NB_DATA-1:0] o_wb_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] mem_q [DEPTH];

    logic [NB_ADDR-1:0] idx;
    logic [1:0]         lane;
    logic [NB_DATA-1:0] word;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [NB_DATA-1:0] wdata_d;
    logic [NB_DATA-1:0] load_d;
    logic               we;
    logic               unused_hi;

    assign idx      = i_result[NB_ADDR+1:2];
    assign lane     = i_result[1:0];
    assign word     = mem_q[idx];
    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = word[{lane[1], 4'b0000} +: 16];
    // Address bits above the word index wrap the memory.
    assign unused_hi = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign we = i_memWrite & ~i_halt & ~i_rst;

    always_comb begin
        wdata_d = word;
        case (i_width)
            2'b00:   wdata_d[{lane, 3'b000} +: 8] = i_data4Mem[7:0];
            2'b01:   wdata_d[{lane[1], 4'b0000} +: 16] = i_data4Mem[15:0];
            default: wdata_d = i_data4Mem;
        endcase
    end

    always_comb begin
        load_d = word;
        case (i_width)
            2'b00: load_d = {{(NB_DATA-8){i_sign_flag & byte_sel[7]}},
                             byte_sel};
            2'b01: load_d = {{(NB_DATA-16){i_sign_flag & half_sel[15]}},
                             half_sel};
            default: load_d = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_write_reg  <= '0;
            o_regWrite   <= 1'b0;
            o_mem2reg    <= 1'b0;
        end else if (!i_halt) begin
            o_read_data  <= i_memRead ? load_d : '0;
            o_alu_result <= i_result;
            o_write_reg  <= i_write_reg;
            o_regWrite   <= i_regWrite;
            o_mem2reg    <= i_mem2reg;
        end
    end

    assign o_wb_data  = o_mem2reg ? o_read_data : o_alu_result;
    assign o_dbg_data = mem_q[i_dbg_addr];

endmodule
